pico_issue_sequencer: RTL and testbench

Program sequencer for the tt_um_pico_riscv execution core. It holds a small host-loaded program buffer and issues each instruction word through the core's strobe/load pin protocol. It runs the core's fixed load → execute → writeback cadence and captures each writeback result for the host. It sits between a host/configuration port and the core's ui_in/uio_in/uo_out/uio_out pins.

---
 rtl/pico_seq_pkg.sv | 21 ++
 rtl/pico_prog_buf.sv | 32 +++
 rtl/pico_issue_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pico_issue_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pico_seq_pkg.sv
// Shared encodings for the pico issue sequencer: FSM states, word width and
// the debug-bus valid bit position.
package pico_seq_pkg;

  localparam int WORD_W        = 15;
  localparam int DBG_VALID_BIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PAUSE   = 3'd4
  } state_t;

  // Core ui_in image: strobe on bit 7, low seven word bits below it.
  function automatic logic [7:0] ui_word(input logic strobe, input logic [WORD_W-1:0] word);
    return {strobe, word[6:0]};
  endfunction

endpackage

// File: rtl/pico_prog_buf.sv
// Host-loaded program store: one synchronous write port, one asynchronous read
// port so the sequencer can register the next word in the same cycle.
module pico_prog_buf
  import pico_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (i_we && (i_waddr == AW'(gi))) begin
          r_mem[gi] <= i_wdata;
        end
      end
    end
  endgenerate

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pico_issue_sequencer.sv
// Issues buffered instruction words to the pico core using its strobe/load pin
// protocol (ISSUE -> EXEC -> CAPTURE) and returns each writeback to the host.
module pico_issue_sequencer
  import pico_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_host_we,
  input  logic [AW-1:0]     i_host_addr,
  input  logic [WORD_W-1:0] i_host_wdata,
  input  logic [AW:0]       i_prog_len,
  input  logic              i_start,
  input  logic              i_step_mode,
  input  logic              i_step,
  input  logic              i_abort,
  output logic [7:0]        o_core_ui,
  output logic [7:0]        o_core_uio,
  input  logic [7:0]        i_core_result,
  input  logic [7:0]        i_core_dbg,
  output logic              o_busy,
  output logic              o_res_valid,
  output logic [7:0]        o_res_data,
  output logic [2:0]        o_res_rd,
  output logic [AW-1:0]     o_res_idx,
  output logic              o_done,
  output logic              o_err
);

  state_t            r_state;
  logic [AW-1:0]     r_idx;
  logic [AW:0]       r_len;
  logic              r_step_mode;
  logic [7:0]        r_core_ui;
  logic [7:0]        r_core_uio;
  logic              r_busy;
  logic              r_res_valid;
  logic [7:0]        r_res_data;
  logic [2:0]        r_res_rd;
  logic [AW-1:0]     r_res_idx;
  logic              r_done;
  logic              r_err;

  state_t            w_state_nxt;
  logic [AW-1:0]     w_idx_nxt;
  logic [AW:0]       w_len_nxt;
  logic              w_step_mode_nxt;
  logic [7:0]        w_core_ui_nxt;
  logic [7:0]        w_core_uio_nxt;
  logic              w_res_valid_nxt;
  logic [7:0]        w_res_data_nxt;
  logic [2:0]        w_res_rd_nxt;
  logic [AW-1:0]     w_res_idx_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic              w_buf_we;
  logic              w_last;
  logic [WORD_W-1:0] w_rdata;
  logic              w_unused_dbg;

  // Upper debug bits carry nothing the sequencer acts on.
  assign w_unused_dbg = ^i_core_dbg[7:4];

  pico_prog_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_buf_we),
    .i_waddr (i_host_addr),
    .i_wdata (i_host_wdata),
    .i_raddr (w_idx_nxt),
    .o_rdata (w_rdata)
  );

  assign w_last = ({1'b0, r_idx} == (r_len - (AW+1)'(1)));

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_len_nxt       = r_len;
    w_step_mode_nxt = r_step_mode;
    w_core_ui_nxt   = {1'b0, r_core_ui[6:0]};
    w_core_uio_nxt  = r_core_uio;
    w_res_valid_nxt = 1'b0;
    w_res_data_nxt  = r_res_data;
    w_res_rd_nxt    = r_res_rd;
    w_res_idx_nxt   = r_res_idx;
    w_done_nxt      = 1'b0;
    w_err_nxt       = r_err;
    w_buf_we        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_buf_we = i_host_we;
        if (i_start) begin
          if (i_prog_len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_len_nxt       = i_prog_len;
            w_step_mode_nxt = i_step_mode;
            w_idx_nxt       = '0;
            w_err_nxt       = 1'b0;
            w_state_nxt     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE:   w_state_nxt = ST_EXEC;
      ST_EXEC:    w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        w_res_valid_nxt = 1'b1;
        w_res_data_nxt  = i_core_result;
        w_res_rd_nxt    = i_core_dbg[2:0];
        w_res_idx_nxt   = r_idx;
        if (!i_core_dbg[DBG_VALID_BIT]) begin
          w_err_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt   = r_idx + AW'(1);
          w_state_nxt = r_step_mode ? ST_PAUSE : ST_ISSUE;
        end
      end
      ST_PAUSE: begin
        if (i_step) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default:    w_state_nxt = ST_IDLE;
    endcase

    // Abort overrides any transition; a result captured this cycle is kept.
    if ((r_state != ST_IDLE) && i_abort) begin
      w_state_nxt = ST_IDLE;
      w_done_nxt  = 1'b1;
    end

    if (w_state_nxt == ST_ISSUE) begin
      w_core_ui_nxt  = ui_word(1'b1, w_rdata);
      w_core_uio_nxt = w_rdata[14:7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_step_mode <= 1'b0;
      r_core_ui   <= '0;
      r_core_uio  <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_rd    <= '0;
      r_res_idx   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_len       <= w_len_nxt;
      r_step_mode <= w_step_mode_nxt;
      r_core_ui   <= w_core_ui_nxt;
      r_core_uio  <= w_core_uio_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_res_valid <= w_res_valid_nxt;
      r_res_data  <= w_res_data_nxt;
      r_res_rd    <= w_res_rd_nxt;
      r_res_idx   <= w_res_idx_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign o_core_ui   = r_core_ui;
  assign o_core_uio  = r_core_uio;
  assign o_busy      = r_busy;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_rd    = r_res_rd;
  assign o_res_idx   = r_res_idx;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_pico_issue_sequencer.sv
// Self-checking bench: a stand-in core answers each strobed word, and every
// run is checked cycle by cycle against the 3-cycle cadence timeline.
module tb_pico_issue_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NONE  = 99;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [14:0]   host_wdata = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    core_ui, core_uio, core_result, core_dbg;
  logic          busy, res_valid, done, err;
  logic [7:0]    res_data;
  logic [2:0]    res_rd;
  logic [AW-1:0] res_idx;

  int checks = 0;
  int failures = 0;
  logic [14:0] buf_model [DEPTH];

  always #5 clk = ~clk;

  pico_issue_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_host_we(host_we), .i_host_addr(host_addr),
    .i_host_wdata(host_wdata), .i_prog_len(prog_len), .i_start(start),
    .i_step_mode(step_mode), .i_step(step), .i_abort(abort),
    .o_core_ui(core_ui), .o_core_uio(core_uio), .i_core_result(core_result),
    .i_core_dbg(core_dbg), .o_busy(busy), .o_res_valid(res_valid),
    .o_res_data(res_data), .o_res_rd(res_rd), .o_res_idx(res_idx),
    .o_done(done), .o_err(err)
  );

  // Stand-in core: latch the word on the strobe, answer with a fixed function of it.
  function automatic logic [7:0] core_fn(input logic [14:0] w);
    if (w == 15'h2505) return 8'd5;
    if (w == 15'h0329) return 8'd8;
    return w[7:0] ^ {1'b0, w[14:8]};
  endfunction

  function automatic logic [2:0] rd_fn(input logic [14:0] w);
    if (w == 15'h2505) return 3'd1;
    if (w == 15'h0329) return 3'd2;
    return w[14:12];
  endfunction

  logic [14:0] core_word = '0;
  int strobe_cnt = 0;
  int run_base = 0;
  int bad_idx = NONE;
  logic core_valid;

  always @(posedge clk) begin
    if (core_ui[7]) begin
      core_word  <= {core_uio, core_ui[6:0]};
      strobe_cnt <= strobe_cnt + 1;
    end
  end
  assign core_valid  = ((strobe_cnt - run_base - 1) != bad_idx);
  assign core_result = core_fn(core_word);
  assign core_dbg    = {4'b0, core_valid, rd_fn(core_word)};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic write_buf(input int addr, input logic [14:0] data);
    host_we = 1'b1; host_addr = AW'(addr); host_wdata = data;
    tick();
    host_we = 1'b0;
    buf_model[addr] = data;
  endtask

  // Checks a whole non-step run against the cadence: ISSUE of k at cycle
  // 1+3k, result k at 4+3k, done at exp_done, busy until done.
  task automatic do_run(input int len, input int bad, input int exp_done,
                        input int exp_nres, input bit exp_err);
    bit exp_strobe, exp_rv;
    int k;
    run_base = strobe_cnt;
    bad_idx = bad;
    prog_len = (AW+1)'(len); step_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
      exp_strobe = (cyc % 3 == 1) && ((cyc - 1) / 3 < exp_nres);
      exp_rv = (cyc >= 4) && ((cyc - 4) % 3 == 0) && ((cyc - 4) / 3 < exp_nres);
      chk("strobe", 32'(core_ui[7]), 32'(exp_strobe));
      chk("res_valid", 32'(res_valid), 32'(exp_rv));
      chk("done", 32'(done), 32'(cyc == exp_done));
      chk("busy", 32'(busy), 32'(cyc < exp_done));
      if (exp_strobe && core_ui[7]) begin
        k = (cyc - 1) / 3;
        chk("issue_word", 32'({core_uio, core_ui[6:0]}), 32'(buf_model[k]));
      end
      if (exp_rv && res_valid) begin
        k = (cyc - 4) / 3;
        chk("res_data", 32'(res_data), 32'(core_fn(buf_model[k])));
        chk("res_rd", 32'(res_rd), 32'(rd_fn(buf_model[k])));
        chk("res_idx", 32'(res_idx), 32'(k));
      end
      $display("run len=%0d cyc=%0d strobe=%0b rv=%0b done=%0b busy=%0b",
               len, cyc, core_ui[7], res_valid, done, busy);
      tick();
    end
    chk("err", 32'(err), 32'(exp_err));
    bad_idx = NONE;
  endtask

  typedef struct {
    int len;
    int bad;
    int exp_done;
    int exp_nres;
    bit exp_err;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int len, bad, nres;
    bit got;

    vecs[0] = '{len: 2,  bad: NONE, exp_done: 7,  exp_nres: 2,  exp_err: 1'b0};
    vecs[1] = '{len: 1,  bad: NONE, exp_done: 4,  exp_nres: 1,  exp_err: 1'b0};
    vecs[2] = '{len: 3,  bad: 1,    exp_done: 7,  exp_nres: 2,  exp_err: 1'b1};
    vecs[3] = '{len: 0,  bad: NONE, exp_done: 1,  exp_nres: 0,  exp_err: 1'b1};
    vecs[4] = '{len: 16, bad: NONE, exp_done: 49, exp_nres: 16, exp_err: 1'b0};
    vecs[5] = '{len: 4,  bad: 0,    exp_done: 4,  exp_nres: 1,  exp_err: 1'b1};

    // Reset state
    tick(); tick();
    chk("rst_core_ui", 32'(core_ui), 0);
    chk("rst_core_uio", 32'(core_uio), 0);
    chk("rst_outs", 32'({busy, res_valid, done, err}), 0);
    chk("rst_res", 32'({res_data, res_rd, res_idx}), 0);
    rst_n = 1'b1;
    tick();

    write_buf(0, 15'h2505);
    write_buf(1, 15'h0329);
    for (int a = 2; a < DEPTH; a++) write_buf(a, 15'($urandom));

    for (int v = 0; v < 6; v++) begin
      $display("vector %0d", v);
      do_run(vecs[v].len, vecs[v].bad, vecs[v].exp_done, vecs[v].exp_nres, vecs[v].exp_err);
    end

    // Step mode: hold in PAUSE, then step issues idx 1 the next cycle.
    run_base = strobe_cnt;
    prog_len = 5'd2; step_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("step_strobe0", 32'(core_ui[7]), 1);
    tick(); tick(); tick();
    chk("step_rv0", 32'(res_valid), 1);
    chk("step_idx0", 32'(res_idx), 0);
    chk("step_data0", 32'(res_data), 5);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("pause_hold", 32'({core_ui[7], res_valid, busy, done}), 32'(4'b0010));
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_strobe1", 32'(core_ui[7]), 1);
    chk("step_word1", 32'({core_uio, core_ui[6:0]}), 32'(buf_model[1]));
    tick(); tick(); tick();
    chk("step_rv1", 32'({res_valid, done}), 32'(2'b11));
    chk("step_data1", 32'({res_data, res_rd, res_idx}), 32'({8'd8, 3'd2, 4'd1}));
    tick();
    chk("step_busy_end", 32'(busy), 0);
    step_mode = 1'b0;

    // Abort during EXEC of idx 0.
    prog_len = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done", 32'({done, busy, core_ui[7], res_valid}), 32'(4'b1000));
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("abort_quiet", 32'({done, busy, core_ui[7], res_valid}), 0);
    end

    // host_we during a run must not change the buffer.
    prog_len = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    host_we = 1'b1; host_addr = '0; host_wdata = ~buf_model[0];
    tick();
    host_we = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (done) got = 1'b1;
      else tick();
    end
    chk("busy_write_run_done", 32'(got), 1);
    tick();
    do_run(1, NONE, 4, 1, 1'b0);

    // Reset mid-run drops the strobe immediately.
    prog_len = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("midrst_strobe_before", 32'(core_ui[7]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'({core_ui, busy}), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized runs against the cadence model.
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < DEPTH; a++) write_buf(a, 15'($urandom));
      len = $urandom_range(1, DEPTH);
      bad = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : NONE;
      nres = (bad < len) ? bad + 1 : len;
      $display("random run %0d len=%0d bad=%0d", r, len, bad);
      do_run(len, bad, 3 * nres + 1, nres, bad < len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
